// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: owns the program counter and the instruction register, and
// runs the instruction-fetch handshake with memory on behalf of the multi-cycle
// control FSM.
//
// Ports
//   CLK, RST_N        clock (rising edge), asynchronous active-low reset
//   FetchReq          control FSM is in its fetch state
//   PCWrite, Branch   unconditional / comparison-qualified PC write requests
//   PCSrc             PC source: 00 jump, 01 PC+1, 10 ALUOut, 11 RegTarget
//   Comparison        ALU equality result used by Branch
//   ALUOut, RegTarget branch target / register-sourced target
//   mem_req, mem_addr fetch read request and address (address is always PC)
//   mem_rdata,mem_ack fetched word and its valid strobe
//   Stall             fetch outstanding; the control FSM must hold its state
//   FetchDone         one-cycle pulse after the IR has been loaded
//   FetchErr          sticky fetch-timeout flag (cleared only by reset)
//   PC, IR            current PC and instruction
//   Opcode, Imm       IR[DATA_W-1:DATA_W-4] and sign-extended IR[7:0]
module fetch_pc_unit #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              FetchReq,
    input  logic              PCWrite,
    input  logic [1:0]        PCSrc,
    input  logic              Branch,
    input  logic              Comparison,
    input  logic [ADDR_W-1:0] ALUOut,
    input  logic [ADDR_W-1:0] RegTarget,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              Stall,
    output logic              FetchDone,
    output logic              FetchErr,
    output logic [ADDR_W-1:0] PC,
    output logic [DATA_W-1:0] IR,
    output logic [3:0]        Opcode,
    output logic [DATA_W-1:0] Imm
);

    localparam int unsigned CNT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StErr
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  wait_cnt;
    logic              in_idle;
    logic              in_wait;
    logic              in_err;
    logic              pc_we;
    logic [ADDR_W-1:0] pc_next;

    assign in_idle = (state == StIdle);
    assign in_wait = (state == StWait);
    assign in_err  = (state == StErr);

    // Request and stall are gated by RST_N so they drop the moment reset
    // asserts, even if the control FSM still holds FetchReq high.
    assign mem_req  = RST_N & ((in_idle & FetchReq) | in_wait);
    assign mem_addr = PC;

    // The ack cycle in WAIT is not stalled, so the fetch-state PC+1 lands on
    // the same edge that loads the IR, exactly as for a zero-wait fetch.
    assign Stall = RST_N & ((in_idle & FetchReq & ~mem_ack) |
                            (in_wait & ~mem_ack) |
                            in_err);

    assign pc_we = (PCWrite | (Branch & Comparison)) & ~Stall;

    always_comb begin
        pc_next = PC;
        unique case (PCSrc)
            2'b00:   pc_next = {PC[ADDR_W-1:12], IR[11:0]};
            2'b01:   pc_next = PC + ADDR_W'(1);
            2'b10:   pc_next = ALUOut;
            2'b11:   pc_next = RegTarget;
            default: pc_next = PC;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            PC <= RESET_PC;
        end else if (pc_we) begin
            PC <= pc_next;
        end
    end

    // Fetch FSM with its registered outputs (IR, FetchDone, FetchErr).
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= StIdle;
            wait_cnt  <= '0;
            IR        <= '0;
            FetchDone <= 1'b0;
            FetchErr  <= 1'b0;
        end else begin
            FetchDone <= 1'b0;
            unique case (state)
                StIdle: begin
                    // An ack without FetchReq is not ours and is ignored.
                    if (FetchReq) begin
                        if (mem_ack) begin
                            IR        <= mem_rdata;
                            FetchDone <= 1'b1;
                        end else begin
                            state    <= StWait;
                            wait_cnt <= CNT_W'(1);
                        end
                    end
                end
                StWait: begin
                    if (mem_ack) begin
                        IR        <= mem_rdata;
                        FetchDone <= 1'b1;
                        state     <= StIdle;
                        wait_cnt  <= '0;
                    end else if (wait_cnt == MAX_CNT) begin
                        state    <= StErr;
                        FetchErr <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                StErr: begin
                    FetchErr <= 1'b1;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

    assign Opcode = IR[DATA_W-1 -: 4];
    assign Imm    = {{(DATA_W-8){IR[7]}}, IR[7:0]};

endmodule
